// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider for the EX stage.
// Handles DIV/DIVU. It stalls the pipeline while iterating and presents the
// quotient on LO and the remainder on HI, with a write strobe for HI/LO.
// A pipeline flush (annul) cancels the operation at any point.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_valid,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             annul,
    input  logic             ext_stall,
    output logic             div_stall,
    output logic             result_valid,
    output logic             hilo_we,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] hi_out
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CW-1:0]    COUNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]    COUNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    COUNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] DATA_ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] DATA_ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] DATA_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

    // Two's-complement negation, applied only when en is set.
    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
        logic [WIDTH-1:0] r;
        if (en) begin
            r = ~v + DATA_ONE;
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic [1:0]       state_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] rem_r;     // partial remainder
    logic [WIDTH-1:0] quo_r;     // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] dvsr_r;    // divisor magnitude
    logic             qsign_r;
    logic             rsign_r;

    logic [WIDTH:0]   rem_ext_s;
    logic [WIDTH:0]   diff_s;
    logic             borrow_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] quo_next_s;

    // One restoring step. The remainder is widened by one bit because
    // 2*rem + 1 can exceed WIDTH bits when the divisor is large.
    always_comb begin
        rem_ext_s  = {rem_r, quo_r[WIDTH-1]};
        diff_s     = rem_ext_s - {1'b0, dvsr_r};
        borrow_s   = diff_s[WIDTH];
        rem_next_s = rem_ext_s[WIDTH-1:0];
        if (!borrow_s) begin
            rem_next_s = diff_s[WIDTH-1:0];
        end else begin
            rem_next_s = rem_ext_s[WIDTH-1:0];
        end
        quo_next_s = {quo_r[WIDTH-2:0], ~borrow_s};
    end

    // Handshake outputs. These are gated by rst and annul so that a flush or
    // reset takes effect on the pipeline within the same cycle.
    always_comb begin
        div_stall    = 1'b0;
        result_valid = 1'b0;
        if (!rst && !annul) begin
            div_stall    = ((state_r == ST_IDLE) && div_valid) || (state_r == ST_BUSY);
            result_valid = (state_r == ST_DONE);
        end else begin
            div_stall    = 1'b0;
            result_valid = 1'b0;
        end
        hilo_we = result_valid && !ext_stall;
    end

    // Sequencer FSM, iteration datapath and HI/LO result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            count_r <= COUNT_ZERO;
            rem_r   <= DATA_ZERO;
            quo_r   <= DATA_ZERO;
            dvsr_r  <= DATA_ZERO;
            qsign_r <= 1'b0;
            rsign_r <= 1'b0;
            lo_out  <= DATA_ZERO;
            hi_out  <= DATA_ZERO;
        end else if (annul) begin
            state_r <= ST_IDLE;
            count_r <= COUNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (div_valid) begin
                        if (opb == DATA_ZERO) begin
                            // Divide by zero: fixed result, no iterations.
                            lo_out  <= DATA_ONES;
                            hi_out  <= opa;
                            state_r <= ST_DONE;
                        end else begin
                            quo_r   <= neg_if(opa, signed_div && opa[WIDTH-1]);
                            dvsr_r  <= neg_if(opb, signed_div && opb[WIDTH-1]);
                            qsign_r <= (opa[WIDTH-1] ^ opb[WIDTH-1]) && signed_div;
                            rsign_r <= opa[WIDTH-1] && signed_div;
                            rem_r   <= DATA_ZERO;
                            count_r <= COUNT_ZERO;
                            state_r <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    rem_r   <= rem_next_s;
                    quo_r   <= quo_next_s;
                    count_r <= count_r + COUNT_ONE;
                    if (count_r == COUNT_LAST) begin
                        lo_out  <= neg_if(quo_next_s, qsign_r);
                        hi_out  <= neg_if(rem_next_s, rsign_r);
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // No restart from here: div_valid still belongs to the
                    // instruction that just finished.
                    if (!ext_stall) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed testbench for div_seq: reset, unsigned/signed division, divide by
// zero, annul, ext_stall hold, mid-operation reset and signed overflow.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_valid;
    logic        signed_div;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        annul;
    logic        ext_stall;
    logic        div_stall;
    logic        result_valid;
    logic        hilo_we;
    logic [31:0] lo_out;
    logic [31:0] hi_out;

    int errors = 0;
    int checks = 0;

    div_seq #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .div_valid    (div_valid),
        .signed_div   (signed_div),
        .opa          (opa),
        .opb          (opb),
        .annul        (annul),
        .ext_stall    (ext_stall),
        .div_stall    (div_stall),
        .result_valid (result_valid),
        .hilo_we      (hilo_we),
        .lo_out       (lo_out),
        .hi_out       (hi_out)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present a request and wait until div_stall drops; n = stall cycles.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, output int n);
        signed_div = sgn;
        opa        = a;
        opb        = b;
        div_valid  = 1'b1;
        #1;
        n = 0;
        while (div_stall === 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        div_valid = 1'b1;
        tick();
        tick();
        checks++; if (div_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", div_stall); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_rv: got %b expected 0", result_valid); end
        checks++; if (hilo_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", hilo_we); end
        checks++; if (lo_out !== 32'h0 || hi_out !== 32'h0) begin errors++; $display("FAIL reset_hilo: got lo=%h hi=%h expected 0/0", lo_out, hi_out); end
        div_valid = 1'b0;
        rst       = 1'b0;
        tick();
        checks++; if (div_stall !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL reset_idle: got stall=%b rv=%b expected 0/0", div_stall, result_valid); end
    endtask

    task automatic test_unsigned();
        int n;
        run_div(1'b0, 32'd100, 32'd7, n);
        checks++; if (n !== 33) begin errors++; $display("FAIL unsigned_stall_len: got %0d expected 33", n); end
        checks++; if (result_valid !== 1'b1 || hilo_we !== 1'b1) begin errors++; $display("FAIL unsigned_done: got rv=%b we=%b expected 1/1", result_valid, hilo_we); end
        checks++; if (lo_out !== 32'd14 || hi_out !== 32'd2) begin errors++; $display("FAIL unsigned_100_7: got lo=%h hi=%h expected 0000000e/00000002", lo_out, hi_out); end
        div_valid = 1'b0;
        tick();
        checks++; if (result_valid !== 1'b0 || hilo_we !== 1'b0 || div_stall !== 1'b0) begin errors++; $display("FAIL unsigned_idle: got rv=%b we=%b stall=%b expected 0/0/0", result_valid, hilo_we, div_stall); end
    endtask

    task automatic test_signed();
        int n;
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, n);
        checks++; if (n !== 33) begin errors++; $display("FAIL signed_stall_len: got %0d expected 33", n); end
        checks++; if (lo_out !== 32'hFFFFFFFD || hi_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL signed_m7_2: got lo=%h hi=%h expected fffffffd/ffffffff", lo_out, hi_out); end
        div_valid = 1'b0;
        tick();
        run_div(1'b0, 32'hFFFFFFF9, 32'd2, n);
        checks++; if (lo_out !== 32'h7FFFFFFC || hi_out !== 32'h00000001) begin errors++; $display("FAIL unsigned_fff9_2: got lo=%h hi=%h expected 7ffffffc/00000001", lo_out, hi_out); end
        div_valid = 1'b0;
        tick();
        run_div(1'b1, 32'd100, 32'hFFFFFFF9, n);
        checks++; if (lo_out !== 32'hFFFFFFF2 || hi_out !== 32'h00000002) begin errors++; $display("FAIL signed_100_m7: got lo=%h hi=%h expected fffffff2/00000002", lo_out, hi_out); end
        div_valid = 1'b0;
        tick();
    endtask

    task automatic test_div_zero();
        int n;
        run_div(1'b1, 32'h12345678, 32'h0, n);
        checks++; if (n !== 1) begin errors++; $display("FAIL divzero_stall_len: got %0d expected 1", n); end
        checks++; if (result_valid !== 1'b1 || hilo_we !== 1'b1) begin errors++; $display("FAIL divzero_done: got rv=%b we=%b expected 1/1", result_valid, hilo_we); end
        checks++; if (lo_out !== 32'hFFFFFFFF || hi_out !== 32'h12345678) begin errors++; $display("FAIL divzero_result: got lo=%h hi=%h expected ffffffff/12345678", lo_out, hi_out); end
        div_valid = 1'b0;
        tick();
    endtask

    task automatic test_annul();
        int n;
        signed_div = 1'b0;
        opa        = 32'd100;
        opb        = 32'd7;
        div_valid  = 1'b1;
        repeat (10) tick();
        checks++; if (div_stall !== 1'b1) begin errors++; $display("FAIL annul_busy: got stall=%b expected 1", div_stall); end
        annul     = 1'b1;
        div_valid = 1'b0;
        #1;
        checks++; if (div_stall !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL annul_same_cycle: got stall=%b rv=%b expected 0/0", div_stall, result_valid); end
        tick();
        annul = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (div_stall !== 1'b0 || result_valid !== 1'b0 || hilo_we !== 1'b0) begin errors++; $display("FAIL annul_idle_%0d: got stall=%b rv=%b we=%b expected 0/0/0", i, div_stall, result_valid, hilo_we); end
            tick();
        end
        checks++; if (lo_out !== 32'hFFFFFFFF || hi_out !== 32'h12345678) begin errors++; $display("FAIL annul_hilo_hold: got lo=%h hi=%h expected ffffffff/12345678", lo_out, hi_out); end
        run_div(1'b0, 32'd1000, 32'd10, n);
        checks++; if (n !== 33) begin errors++; $display("FAIL annul_restart_len: got %0d expected 33", n); end
        checks++; if (lo_out !== 32'd100 || hi_out !== 32'd0) begin errors++; $display("FAIL annul_restart: got lo=%h hi=%h expected 00000064/00000000", lo_out, hi_out); end
        div_valid = 1'b0;
        tick();
    endtask

    task automatic test_ext_stall();
        int n;
        ext_stall = 1'b1;
        run_div(1'b0, 32'hFFFFFFFF, 32'h10, n);
        checks++; if (n !== 33) begin errors++; $display("FAIL ext_stall_len: got %0d expected 33", n); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (result_valid !== 1'b1 || hilo_we !== 1'b0 || div_stall !== 1'b0) begin errors++; $display("FAIL ext_stall_hold_%0d: got rv=%b we=%b stall=%b expected 1/0/0", i, result_valid, hilo_we, div_stall); end
            checks++; if (lo_out !== 32'h0FFFFFFF || hi_out !== 32'h0000000F) begin errors++; $display("FAIL ext_stall_hilo_%0d: got lo=%h hi=%h expected 0fffffff/0000000f", i, lo_out, hi_out); end
            tick();
        end
        ext_stall = 1'b0;
        #1;
        checks++; if (result_valid !== 1'b1 || hilo_we !== 1'b1) begin errors++; $display("FAIL ext_stall_release: got rv=%b we=%b expected 1/1", result_valid, hilo_we); end
        tick();
        div_valid = 1'b0;
        #1;
        checks++; if (result_valid !== 1'b0 || hilo_we !== 1'b0 || div_stall !== 1'b0) begin errors++; $display("FAIL ext_stall_no_restart: got rv=%b we=%b stall=%b expected 0/0/0", result_valid, hilo_we, div_stall); end
        tick();
        checks++; if (div_stall !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL ext_stall_idle: got stall=%b rv=%b expected 0/0", div_stall, result_valid); end
    endtask

    task automatic test_rst_mid();
        int n;
        signed_div = 1'b0;
        opa        = 32'd100;
        opb        = 32'd7;
        div_valid  = 1'b1;
        repeat (20) tick();
        checks++; if (div_stall !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: got stall=%b expected 1", div_stall); end
        rst       = 1'b1;
        div_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (lo_out !== 32'h0 || hi_out !== 32'h0 || result_valid !== 1'b0 || hilo_we !== 1'b0 || div_stall !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs: got lo=%h hi=%h rv=%b we=%b stall=%b expected all 0", lo_out, hi_out, result_valid, hilo_we, div_stall); end
        tick();
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, n);
        checks++; if (n !== 33) begin errors++; $display("FAIL overflow_len: got %0d expected 33", n); end
        checks++; if (lo_out !== 32'h80000000 || hi_out !== 32'h0) begin errors++; $display("FAIL overflow_result: got lo=%h hi=%h expected 80000000/00000000", lo_out, hi_out); end
        div_valid = 1'b0;
        tick();
    endtask

    // Test sequence.
    initial begin
        rst        = 1'b1;
        div_valid  = 1'b0;
        signed_div = 1'b0;
        opa        = 32'h0;
        opb        = 32'h0;
        annul      = 1'b0;
        ext_stall  = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_annul();
        test_ext_stall();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle divide sequencer for the EX stage of the 5-stage MIPS pipeline.
- Accepts the EX-stage divide request (DIV/DIVU decoded into div_valid/signed_div) with its two operands.
- Runs a 32-iteration radix-2 restoring division, stalling the pipeline while busy.
- Presents quotient (LO) and remainder (HI) with a write strobe for the HI/LO registers; cancellable by a pipeline flush.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- div_valid  in  1  EX-stage instruction is DIV/DIVU
- signed_div  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start
- opa  in  WIDTH  dividend (rs), sampled at start
- opb  in  WIDTH  divisor (rt), sampled at start
- annul  in  1  flush of EX instruction; cancels any operation
- ext_stall  in  1  pipeline held by another source; result must be held
- div_stall  out  1  stall request to hazard unit (combinational)
- result_valid  out  1  hi/lo outputs valid; EX instruction may complete
- hilo_we  out  1  HI/LO write strobe (= result_valid & ~ext_stall)
- lo_out  out  WIDTH  quotient
- hi_out  out  WIDTH  remainder

Behaviour:
- Reset: state = IDLE, count = 0, lo_out = 0, hi_out = 0, result_valid = 0, hilo_we = 0, div_stall = 0 (forced low while rst = 1).
- States: IDLE, BUSY, DONE.
- IDLE:
  - div_valid & ~annul: latch |opa|, |opb| (abs only if signed_div, else raw), the quotient sign (opa[31]^opb[31]) & signed_div and the remainder sign opa[31] & signed_div; clear partial remainder; count = 0; go to BUSY.
  - If opb == 0: go directly to DONE with lo_out = all ones and hi_out = opa (raw), no sign fix-up.
- BUSY, each cycle:
  - Shift {rem, quo} left by one and trial-subtract the divisor.
  - If there is no borrow: rem = difference and quo LSB = 1; else quo LSB = 0.
  - count++.
  - At count == WIDTH-1, apply sign fix-up (negate quotient if qsign, negate remainder if rsign), load lo_out/hi_out and go to DONE.
- DONE:
  - result_valid = 1.
  - If ~ext_stall: go to IDLE. Otherwise stay in DONE with outputs stable.
  - No restart from DONE, even if div_valid is still high (it is the same instruction).
- div_stall = ~rst & ~annul & ((IDLE & div_valid) | BUSY).
  - Deasserted in DONE, so the EX instruction advances at the edge leaving DONE.
- Latency for a nonzero divisor:
  - Request seen in IDLE at cycle 0; BUSY spans cycles 1..WIDTH; DONE at cycle WIDTH+1.
  - div_stall is high for WIDTH+1 = 33 consecutive cycles.
- Latency for a zero divisor: DONE at cycle 1; div_stall is high for 1 cycle.
- annul has priority over everything except rst. In any state it sends the FSM to IDLE at the next edge, with result_valid/hilo_we = 0 in that cycle. lo_out/hi_out keep their previous values.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0. This is the natural wrap result; no trap.
- rst mid-operation: returns to IDLE immediately at the edge and all outputs go to reset values.
- lo_out/hi_out change only on entry to DONE, and hold otherwise.

Test Plan:
- Unsigned 100 / 7 (signed_div = 0) -> div_stall high 33 cycles; then result_valid = 1, lo = 14, hi = 2, hilo_we = 1 for 1 cycle; FSM back in IDLE the next cycle.
- Signed -7 / 2 (opa = 0xFFFFFFF9, opb = 2) -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. Unsigned with the same operands -> lo = 0x7FFFFFFC, hi = 1.
- Divide by zero: opa = 0x12345678, opb = 0 -> div_stall high 1 cycle; lo = 0xFFFFFFFF, hi = 0x12345678.
- annul at BUSY cycle 10 -> IDLE next cycle, div_stall low, no hilo_we, hi/lo unchanged. A new request afterwards completes correctly.
- ext_stall high for 3 cycles in DONE while div_valid stays high -> result_valid held 3 cycles with hilo_we = 0; single hilo_we pulse when ext_stall drops; no second division started.
- rst asserted at BUSY cycle 20 -> all outputs 0 next cycle. Signed 0x80000000 / 0xFFFFFFFF afterwards -> lo = 0x80000000, hi = 0.
